fp_compose_seq: RTL

FP_COMPOSE_SEQ -- requirements
Module: fp_compose_seq

---
 rtl/fp_compose_seq.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/fp_compose_seq.sv
// fp_compose_seq: sequential normalise / round / pack of a wide-mantissa float
// into an IEEE-754 style packed word, with overflow, underflow and inexact flags.
module fp_compose_seq #(
  parameter  int unsigned FPWID = 32,
  localparam int unsigned EMSB  = (FPWID >= 128) ? 14 :
                                  (FPWID >= 64)  ? 10 :
                                  (FPWID >= 32)  ? 7  : 4,
  localparam int unsigned FMSB  = FPWID - EMSB - 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              ld,
  input  logic              sgn,
  input  logic [EMSB+2:0]   xi,
  input  logic [FMSB+5:0]   mi,
  input  logic [2:0]        rm,
  input  logic              inf_i,
  input  logic              nan_i,
  output logic [FPWID-1:0]  o,
  output logic              done,
  output logic              busy,
  output logic              of,
  output logic              uf,
  output logic              inex
);

  localparam int unsigned MW = FMSB + 6;   // carry, hidden, fraction, guard, round, sticky
  localparam int unsigned EW = EMSB + 4;   // exponent plus headroom for two increments
  localparam int unsigned FW = FMSB + 3;   // carry, hidden, fraction
  localparam logic [EW-1:0] EXP_MAX = EW'((1 << (EMSB + 1)) - 1);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, PACK} state_t;

  state_t          state_q;
  logic            sgn_q;
  logic [EW-1:0]   exp_q;
  logic [MW-1:0]   man_q;
  logic [2:0]      rm_q;
  logic            inf_q;
  logic            nan_q;
  logic            zero_q;
  logic            ovf_q;
  logic            rinex_q;
  logic [FPWID-1:0] o_q;
  logic            done_q;
  logic            busy_q;
  logic            of_q;
  logic            uf_q;
  logic            inex_q;

  logic            lsb_c;
  logic            grd_c;
  logic            rnd_c;
  logic            stk_c;
  logic            grs_c;
  logic            inc_ne_c;
  logic            inc_c;
  logic [FW-1:0]   sum_c;
  logic            rcarry_c;
  logic [FMSB+1:0] rman_c;
  logic [EW-1:0]   rexp_c;
  logic [EW-1:0]   nexp_c;
  logic            ne_carry_c;
  logic            ovf_c;

  // Rounding increment and rounded mantissa/exponent for the ROUND state.
  // Overflow is also judged at round-to-nearest so clamping modes still report it.
  always_comb begin
    lsb_c    = man_q[3];
    grd_c    = man_q[2];
    rnd_c    = man_q[1];
    stk_c    = man_q[0];
    grs_c    = grd_c | rnd_c | stk_c;
    inc_ne_c = grd_c & (rnd_c | stk_c | lsb_c);
    case (rm_q)
      3'd1:    inc_c = 1'b0;
      3'd2:    inc_c = sgn_q & grs_c;
      3'd3:    inc_c = ~sgn_q & grs_c;
      3'd4:    inc_c = grd_c;
      default: inc_c = inc_ne_c;
    endcase
    sum_c      = man_q[MW-1:3] + FW'(inc_c);
    rcarry_c   = sum_c[FW-1];
    rman_c     = rcarry_c ? {1'b1, {(FMSB+1){1'b0}}} : sum_c[FMSB+1:0];
    rexp_c     = exp_q + EW'(rcarry_c);
    ne_carry_c = inc_ne_c & (&man_q[FMSB+4:3]);
    nexp_c     = exp_q + EW'(ne_carry_c);
    ovf_c      = (rexp_c >= EXP_MAX) || (nexp_c >= EXP_MAX);
  end

  logic [FPWID-1:0] pk_o_c;
  logic             pk_of_c;
  logic             pk_uf_c;
  logic             pk_inex_c;
  logic             clamp_c;
  logic [EMSB:0]    efield_c;

  // Packed result and flags presented to the output registers in PACK.
  always_comb begin
    pk_o_c    = '0;
    pk_of_c   = 1'b0;
    pk_uf_c   = 1'b0;
    pk_inex_c = 1'b0;
    clamp_c   = (rm_q == 3'd1) || (rm_q == 3'd2 && !sgn_q) || (rm_q == 3'd3 && sgn_q);
    efield_c  = man_q[FMSB+4] ? exp_q[EMSB:0] : '0;
    if (nan_q) begin
      pk_o_c = {sgn_q, {(EMSB+1){1'b1}}, 1'b1, {FMSB{1'b0}}};
    end else if (inf_q) begin
      pk_o_c = {sgn_q, {(EMSB+1){1'b1}}, {(FMSB+1){1'b0}}};
    end else if (zero_q) begin
      pk_o_c = {sgn_q, {(FPWID-1){1'b0}}};
    end else if (ovf_q) begin
      pk_of_c   = 1'b1;
      pk_inex_c = 1'b1;
      pk_o_c    = clamp_c ? {sgn_q, {EMSB{1'b1}}, 1'b0, {(FMSB+1){1'b1}}}
                          : {sgn_q, {(EMSB+1){1'b1}}, {(FMSB+1){1'b0}}};
    end else begin
      pk_o_c    = {sgn_q, efield_c, man_q[FMSB+3:3]};
      pk_inex_c = rinex_q;
      pk_uf_c   = (efield_c == '0) && rinex_q;
    end
  end

  // Control FSM with operand datapath and registered outputs.
  // Special operands skip normalisation and pass through ROUND untouched in effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sgn_q   <= 1'b0;
      exp_q   <= '0;
      man_q   <= '0;
      rm_q    <= '0;
      inf_q   <= 1'b0;
      nan_q   <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      rinex_q <= 1'b0;
      o_q     <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      of_q    <= 1'b0;
      uf_q    <= 1'b0;
      inex_q  <= 1'b0;
    end else if (ce) begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ld) begin
            sgn_q  <= sgn;
            exp_q  <= (xi == '0) ? EW'(1) : EW'(xi);
            man_q  <= mi;
            rm_q   <= rm;
            inf_q  <= inf_i;
            nan_q  <= nan_i;
            zero_q <= (mi == '0);
            busy_q <= 1'b1;
            state_q <= (nan_i || inf_i || mi == '0) ? ROUND : NORM;
          end
        end
        NORM: begin
          if (man_q[MW-1]) begin
            man_q <= {1'b0, man_q[MW-1:2], man_q[1] | man_q[0]};
            exp_q <= exp_q + EW'(1);
          end else if (!man_q[MW-2] && exp_q > EW'(1)) begin
            man_q <= {man_q[MW-2:0], 1'b0};
            exp_q <= exp_q - EW'(1);
          end else begin
            state_q <= ROUND;
          end
        end
        ROUND: begin
          man_q   <= {1'b0, rman_c, 3'b000};
          exp_q   <= rexp_c;
          rinex_q <= grs_c;
          ovf_q   <= ovf_c;
          state_q <= PACK;
        end
        PACK: begin
          o_q     <= pk_o_c;
          of_q    <= pk_of_c;
          uf_q    <= pk_uf_c;
          inex_q  <= pk_inex_c;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o    = o_q;
  assign done = done_q;
  assign busy = busy_q;
  assign of   = of_q;
  assign uf   = uf_q;
  assign inex = inex_q;

endmodule
